cache_axi_rd_arbiter: RTL and testbench
=======================================

Name: cache_axi_rd_arbiter

Overview:
- Sits directly downstream of the instruction cache and the data cache. Muxes their two read-request ports onto the single AXI read master (AR/R channels) of the CPU top.
- At most one read burst is outstanding. It is granted round-robin when both caches request at once.
- Returned beats are routed back to the granted cache only.
- A beat counter checks each burst length and flags a sticky protocol error.

Parameters:
- ID_I, 4'd0, arid driven for instruction-side bursts.
- ID_D, 4'd1, arid driven for data-side bursts.

Ports:
- clk  input  1  system clock, all state on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- i_araddr, d_araddr  input  32  burst start address from icache / dcache.
- i_arlen, d_arlen  input  8  AXI length (beats-1) from each cache.
- i_arvalid, d_arvalid  input  1  read request from each cache.
- i_arready, d_arready  output  1  address accepted, to each cache.
- i_rdata, d_rdata  output  32  read data to each cache.
- i_rvalid, d_rvalid  output  1  beat valid, granted cache only.
- i_rlast, d_rlast  output  1  last beat, granted cache only.
- i_rready, d_rready  input  1  beat accept from each cache.
- arid  output  4  ID_I or ID_D per grant.
- araddr  output  32  granted cache's address.
- arlen  output  8  granted cache's length.
- arsize  output  3  constant 3'b010 (4 bytes).
- arburst  output  2  constant 2'b01 (INCR).
- arvalid  output  1  AXI address valid.
- arready  input  1  AXI address ready.
- rid  input  4  AXI read ID (checked, not used for routing).
- rdata  input  32  AXI read data.
- rvalid, rlast  input  1  AXI beat valid / last.
- rready  output  1  AXI beat ready.
- err  output  1  sticky protocol error.

Behaviour:
- Reset (resetn=0, asynchronous):
  - State returns to IDLE; last_grant=D; beat_cnt=0; err=0.
  - All valid/ready outputs are 0 immediately.
  - Address/ID outputs are don't-care while arvalid=0; they are driven 0.
- States:
  - IDLE: no grant.
    - If any X_arvalid is high, latch grant and go to AR next cycle.
    - Both requesting: grant the side opposite last_grant.
    - One requesting: grant that side.
    - last_grant is updated on the grant.
  - AR: arvalid=1; araddr/arlen/arid are muxed from the latched grant.
    - Granted X_arready = arready; the other side's arready = 0.
    - On arvalid&arready: latch arlen into len_q, clear beat_cnt, go to R.
  - R: rready = granted X_rready.
    - Granted X_rvalid/X_rlast = rvalid/rlast; the other side sees 0.
    - i_rdata and d_rdata both = rdata.
    - Each rvalid&rready beat increments beat_cnt (8-bit, wraps at 255).
    - On rvalid&rready&rlast: go to IDLE.
- Latency:
  - Request seen in IDLE at cycle n gives arvalid at n+1.
  - After the last beat at cycle m, IDLE at m+1; the next grant is earliest at m+1, giving arvalid at m+2.
- Client contract: each cache holds X_araddr/X_arlen/X_arvalid stable until X_arready.
  - A request arriving while the other side owns the bus waits. It is granted at the next IDLE.
  - A valid deasserted before grant is simply not granted.
- err set (sticky until reset) when either of these occurs:
  - A beat with rlast=1 and beat_cnt!=len_q.
  - A beat with rlast=0 and beat_cnt==len_q.
  - A beat with rid not equal to the granted ID.
  - Routing is unaffected by err.
- rvalid while not in R: ignored; rready=0 there.
- arlen=0 (single beat): AR then one R beat; rlast is expected on beat 0.

Decomposition:
- Shared package: AXI constants (SIZE_4B=3'b010, BURST_INCR=2'b01).
- Shared package: state encoding (IDLE/AR/R) and the grant encoding (GNT_I/GNT_D).
- No sub-module needed. The round-robin choice is a few lines inline.

Test Plan:
- Reset, then i_arvalid=1 at 0xBFC00000 with arlen=0 → arvalid at n+1, arid=0.
  - Then rvalid&rlast with rdata=0x3C1DBFC0 → i_rvalid=1, i_rdata=0x3C1DBFC0, d_rvalid=0; IDLE next cycle.
- d_arvalid at 0x80001000 with arlen=7 and 8 beats, rlast on beat 8 → d_rvalid/d_rlast follow rvalid/rlast, rid=1 accepted, err=0.
- i_arvalid and d_arvalid rise on the same cycle after reset → I granted first (last_grant=D).
  - D is granted at the IDLE after I's last beat.
  - A second simultaneous pair is granted D first.
- arready held low 5 cycles → arvalid, araddr, arlen and arid stay stable for those 5 cycles.
  - Ungranted X_arready=0 throughout.
  - The AR handshake occurs on the cycle arready=1.
- arlen=3 but rlast arrives on beat 2 → err=1 and stays 1 through later clean bursts until resetn=0.
- resetn pulled low during the R phase of a burst → arvalid/rready/X_rvalid=0 immediately and state IDLE.
  - A new i request after release is granted normally.

Source files
------------

// File: rtl/cache_axi_rd_arbiter_pkg.sv
// Shared types and AXI constants for the icache/dcache read arbiter.
package cache_axi_rd_arbiter_pkg;

    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] BURST_INCR = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_AR,
        ST_R
    } state_e;

    typedef enum logic {
        GNT_I,
        GNT_D
    } grant_e;

    // Round-robin choice: a lone requester wins, a tie goes to the side not served last.
    function automatic grant_e rr_pick(input logic req_i, input logic req_d, input grant_e last);
        grant_e pick;
        if (req_i && req_d) begin
            pick = (last == GNT_D) ? GNT_I : GNT_D;
        end else if (req_i) begin
            pick = GNT_I;
        end else begin
            pick = GNT_D;
        end
        return pick;
    endfunction

endpackage

// File: rtl/cache_axi_rd_arbiter.sv
// Muxes icache and dcache read requests onto one AXI read master, one burst at a time,
// routing returned beats to the granted cache and flagging burst-length / ID errors.
module cache_axi_rd_arbiter
    import cache_axi_rd_arbiter_pkg::*;
#(
    parameter logic [3:0] ID_I = 4'd0,
    parameter logic [3:0] ID_D = 4'd1
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic [31:0] i_araddr,
    input  logic [7:0]  i_arlen,
    input  logic        i_arvalid,
    output logic        i_arready,
    output logic [31:0] i_rdata,
    output logic        i_rvalid,
    output logic        i_rlast,
    input  logic        i_rready,

    input  logic [31:0] d_araddr,
    input  logic [7:0]  d_arlen,
    input  logic        d_arvalid,
    output logic        d_arready,
    output logic [31:0] d_rdata,
    output logic        d_rvalid,
    output logic        d_rlast,
    input  logic        d_rready,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    input  logic        rlast,
    output logic        rready,

    output logic        err
);

    state_e     state_q, state_d;
    grant_e     last_grant_q, last_grant_d;
    logic [7:0] len_q;
    logic [7:0] beat_cnt_q;
    logic       err_q;

    logic       gnt_d_side;
    logic       in_ar;
    logic       in_r;
    logic [3:0] gnt_id;
    logic       beat;
    logic       bad_beat;

    // last_grant_q doubles as the current grant while a burst is in flight.
    assign gnt_d_side = (last_grant_q == GNT_D);
    assign in_ar      = (state_q == ST_AR);
    assign in_r       = (state_q == ST_R);
    assign gnt_id     = gnt_d_side ? ID_D : ID_I;

    // NOTE: every signal written in always_comb gets a default first so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (i_arvalid || d_arvalid) begin
                    last_grant_d = rr_pick(i_arvalid, d_arvalid, last_grant_q);
                    state_d      = ST_AR;
                end
            end
            ST_AR: begin
                if (arready) begin
                    state_d = ST_R;
                end
            end
            ST_R: begin
                if (beat && rlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign arvalid = in_ar;
    assign arid    = in_ar ? gnt_id : 4'd0;
    assign araddr  = in_ar ? (gnt_d_side ? d_araddr : i_araddr) : 32'd0;
    assign arlen   = in_ar ? (gnt_d_side ? d_arlen : i_arlen) : 8'd0;
    assign arsize  = SIZE_4B;
    assign arburst = BURST_INCR;

    assign i_arready = in_ar && !gnt_d_side && arready;
    assign d_arready = in_ar &&  gnt_d_side && arready;

    assign rready   = in_r && (gnt_d_side ? d_rready : i_rready);
    assign i_rvalid = in_r && !gnt_d_side && rvalid;
    assign d_rvalid = in_r &&  gnt_d_side && rvalid;
    assign i_rlast  = in_r && !gnt_d_side && rvalid && rlast;
    assign d_rlast  = in_r &&  gnt_d_side && rvalid && rlast;
    assign i_rdata  = rdata;
    assign d_rdata  = rdata;

    assign beat = in_r && rvalid && rready;

    // rlast must coincide exactly with the beat whose index equals the granted length.
    assign bad_beat = (rlast != (beat_cnt_q == len_q)) || (rid != gnt_id);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GNT_D;
            len_q        <= 8'd0;
            beat_cnt_q   <= 8'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            if (in_ar && arready) begin
                len_q      <= arlen;
                beat_cnt_q <= 8'd0;
            end else if (beat) begin
                beat_cnt_q <= beat_cnt_q + 8'd1;
            end
            if (beat && bad_beat) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_cache_axi_rd_arbiter.sv
// Self-checking bench: the bench plays both caches and the AXI slave, predicting grants,
// routing and the sticky error from a transaction-level model of the arbiter's rules.
module tb_cache_axi_rd_arbiter;

    logic        clk = 1'b0;
    logic        resetn;

    logic [31:0] i_araddr, d_araddr;
    logic [7:0]  i_arlen, d_arlen;
    logic        i_arvalid, d_arvalid;
    logic        i_arready, d_arready;
    logic [31:0] i_rdata, d_rdata;
    logic        i_rvalid, d_rvalid, i_rlast, d_rlast;
    logic        i_rready, d_rready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        axi_arready;
    logic [3:0]  axi_rid;
    logic [31:0] axi_rdata;
    logic        axi_rvalid, axi_rlast;
    logic        rready;
    logic        err;

    // Client side state, index 0 = icache, 1 = dcache.
    logic [31:0] req_addr [2];
    logic [7:0]  req_len  [2];
    logic        cli_valid [2];
    logic        cli_rready [2];

    // Model state.
    int model_last;
    bit err_exp;

    int n_checks = 0;
    int n_fail   = 0;

    assign i_araddr  = req_addr[0];
    assign d_araddr  = req_addr[1];
    assign i_arlen   = req_len[0];
    assign d_arlen   = req_len[1];
    assign i_arvalid = cli_valid[0];
    assign d_arvalid = cli_valid[1];
    assign i_rready  = cli_rready[0];
    assign d_rready  = cli_rready[1];

    cache_axi_rd_arbiter dut (
        .clk       (clk),
        .resetn    (resetn),
        .i_araddr  (i_araddr),
        .i_arlen   (i_arlen),
        .i_arvalid (i_arvalid),
        .i_arready (i_arready),
        .i_rdata   (i_rdata),
        .i_rvalid  (i_rvalid),
        .i_rlast   (i_rlast),
        .i_rready  (i_rready),
        .d_araddr  (d_araddr),
        .d_arlen   (d_arlen),
        .d_arvalid (d_arvalid),
        .d_arready (d_arready),
        .d_rdata   (d_rdata),
        .d_rvalid  (d_rvalid),
        .d_rlast   (d_rlast),
        .d_rready  (d_rready),
        .arid      (arid),
        .araddr    (araddr),
        .arlen     (arlen),
        .arsize    (arsize),
        .arburst   (arburst),
        .arvalid   (arvalid),
        .arready   (axi_arready),
        .rid       (axi_rid),
        .rdata     (axi_rdata),
        .rvalid    (axi_rvalid),
        .rlast     (axi_rlast),
        .rready    (rready),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic side_arready(input int s);
        return (s == 1) ? d_arready : i_arready;
    endfunction

    function automatic logic side_rvalid(input int s);
        return (s == 1) ? d_rvalid : i_rvalid;
    endfunction

    function automatic logic side_rlast(input int s);
        return (s == 1) ? d_rlast : i_rlast;
    endfunction

    // Which cache should own the next burst, given who is asking and who went last.
    function automatic int model_pick();
        if (cli_valid[0] && cli_valid[1]) return (model_last == 1) ? 0 : 1;
        return cli_valid[0] ? 0 : 1;
    endfunction

    task automatic request(input int side, input logic [31:0] addr, input logic [7:0] len);
        req_addr[side]  = addr;
        req_len[side]   = len;
        cli_valid[side] = 1'b1;
    endtask

    // Called at the negedge a new request is raised in IDLE: arvalid must not be up yet.
    task automatic start_req();
        #1;
        check("req_idle_arvalid", arvalid, 1'b0);
        @(negedge clk);
    endtask

    // Serves one burst starting at the negedge where the arbiter should be in AR.
    task automatic serve_one(input int ar_delay, input int last_beat_ovr, input bit bad_rid,
                             input logic [31:0] dbase, input bit rand_timing, input bit raise_other);
        int g, o, last_b, b;
        logic [31:0] exp_addr;
        logic [7:0]  exp_len;
        g        = model_pick();
        o        = 1 - g;
        exp_addr = req_addr[g];
        exp_len  = req_len[g];
        last_b   = (last_beat_ovr >= 0) ? last_beat_ovr : int'(exp_len);

        for (int k = 0; k <= ar_delay; k++) begin
            axi_arready = (k == ar_delay);
            #1;
            check("ar_valid", arvalid, 1'b1);
            check("ar_id", arid, g);
            check("ar_addr", araddr, exp_addr);
            check("ar_len", arlen, exp_len);
            check("ar_ready_gnt", side_arready(g), axi_arready);
            check("ar_ready_other", side_arready(o), 1'b0);
            if (k == 0) begin
                check("ar_size", arsize, 3'b010);
                check("ar_burst", arburst, 2'b01);
            end
            @(negedge clk);
        end
        axi_arready  = 1'b0;
        cli_valid[g] = 1'b0;
        model_last   = g;

        b = 0;
        while (b <= last_b) begin
            cli_rready[g] = rand_timing ? ($urandom_range(2) != 0) : 1'b1;
            cli_rready[o] = 1'($urandom_range(1));
            if (rand_timing && $urandom_range(3) == 0) begin
                axi_rvalid = 1'b0;
                axi_rlast  = 1'b0;
                #1;
                check("gap_rvalid", side_rvalid(g), 1'b0);
                check("gap_rready", rready, cli_rready[g]);
            end else begin
                axi_rvalid = 1'b1;
                axi_rlast  = (b == last_b);
                axi_rid    = bad_rid ? 4'(o) : 4'(g);
                axi_rdata  = dbase + 32'(b);
                if (raise_other && b == 0 && !cli_valid[o]) begin
                    request(o, $urandom, 8'($urandom_range(15)));
                end
                #1;
                check("r_rready", rready, cli_rready[g]);
                check("r_rvalid_gnt", side_rvalid(g), 1'b1);
                check("r_rlast_gnt", side_rlast(g), axi_rlast);
                check("r_rvalid_other", side_rvalid(o), 1'b0);
                check("r_rlast_other", side_rlast(o), 1'b0);
                check("r_i_rdata", i_rdata, axi_rdata);
                check("r_d_rdata", d_rdata, axi_rdata);
                check("r_arready_other", side_arready(o), 1'b0);
                if (cli_rready[g]) begin
                    if ((axi_rlast && b != int'(exp_len)) || (!axi_rlast && b == int'(exp_len)) || bad_rid)
                        err_exp = 1'b1;
                    b++;
                end
            end
            @(negedge clk);
        end
        axi_rvalid = 1'b0;
        axi_rlast  = 1'b0;
        #1;
        check("end_idle_arvalid", arvalid, 1'b0);
        check("end_rready", rready, 1'b0);
        check("end_err", err, err_exp);
    endtask

    initial begin
        resetn        = 1'b0;
        axi_arready   = 1'b0;
        axi_rid       = 4'd0;
        axi_rdata     = 32'd0;
        axi_rvalid    = 1'b0;
        axi_rlast     = 1'b0;
        for (int s = 0; s < 2; s++) begin
            req_addr[s]   = 32'd0;
            req_len[s]    = 8'd0;
            cli_valid[s]  = 1'b0;
            cli_rready[s] = 1'b0;
        end
        model_last = 1;
        err_exp    = 1'b0;

        #12;
        check("rst_arvalid", arvalid, 1'b0);
        check("rst_i_arready", i_arready, 1'b0);
        check("rst_d_arready", d_arready, 1'b0);
        check("rst_rready", rready, 1'b0);
        check("rst_i_rvalid", i_rvalid, 1'b0);
        check("rst_d_rvalid", d_rvalid, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_araddr", araddr, 32'd0);
        check("rst_arid", arid, 4'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Single-beat icache fetch from the reset vector.
        request(0, 32'hBFC0_0000, 8'd0);
        start_req();
        serve_one(0, -1, 1'b0, 32'h3C1D_BFC0, 1'b0, 1'b0);

        // Eight-beat dcache line fill.
        @(negedge clk);
        request(1, 32'h8000_1000, 8'd7);
        start_req();
        serve_one(0, -1, 1'b0, 32'h1234_0000, 1'b0, 1'b0);

        // Simultaneous pair, then a lone I, then another pair.
        @(negedge clk);
        request(0, 32'h0000_0100, 8'd1);
        request(1, 32'h0000_0200, 8'd2);
        start_req();
        serve_one(0, -1, 1'b0, 32'hA000_0000, 1'b0, 1'b0);
        @(negedge clk);
        serve_one(0, -1, 1'b0, 32'hA100_0000, 1'b0, 1'b0);
        @(negedge clk);
        request(0, 32'h0000_0300, 8'd0);
        start_req();
        serve_one(0, -1, 1'b0, 32'hA200_0000, 1'b0, 1'b0);
        @(negedge clk);
        request(0, 32'h0000_0400, 8'd1);
        request(1, 32'h0000_0500, 8'd1);
        start_req();
        serve_one(0, -1, 1'b0, 32'hA300_0000, 1'b0, 1'b0);
        @(negedge clk);
        serve_one(0, -1, 1'b0, 32'hA400_0000, 1'b0, 1'b0);

        // Address channel stalled for five cycles.
        @(negedge clk);
        request(1, 32'hDEAD_BEE0, 8'd4);
        start_req();
        serve_one(5, -1, 1'b0, 32'hB000_0000, 1'b0, 1'b0);

        // Early rlast sets the sticky error; later clean bursts keep it set.
        @(negedge clk);
        request(0, 32'h0000_1000, 8'd3);
        start_req();
        serve_one(0, 2, 1'b0, 32'hC000_0000, 1'b0, 1'b0);
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            request(n, 32'h0000_2000 + 32'(n), 8'd2);
            start_req();
            serve_one(0, -1, 1'b0, 32'hC100_0000, 1'b0, 1'b0);
        end

        // Reset asserted mid-burst.
        @(negedge clk);
        request(0, 32'h0000_3000, 8'd3);
        start_req();
        axi_arready = 1'b1;
        @(negedge clk);
        axi_arready   = 1'b0;
        cli_valid[0]  = 1'b0;
        cli_rready[0] = 1'b1;
        axi_rvalid    = 1'b1;
        axi_rlast     = 1'b0;
        axi_rid       = 4'd0;
        #1;
        check("prerst_i_rvalid", i_rvalid, 1'b1);
        resetn = 1'b0;
        #1;
        check("midrst_arvalid", arvalid, 1'b0);
        check("midrst_rready", rready, 1'b0);
        check("midrst_i_rvalid", i_rvalid, 1'b0);
        check("midrst_err", err, 1'b0);
        model_last = 1;
        err_exp    = 1'b0;
        axi_rvalid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        request(0, 32'h0000_4000, 8'd1);
        start_req();
        serve_one(0, -1, 1'b0, 32'hD000_0000, 1'b0, 1'b0);

        // Randomised traffic with stalls, gaps, overlapping requests and occasional bad IDs.
        for (int it = 0; it < 40; it++) begin
            if (!cli_valid[0] && !cli_valid[1]) begin
                case ($urandom_range(2))
                    0: request(0, $urandom, 8'($urandom_range(15)));
                    1: request(1, $urandom, 8'($urandom_range(15)));
                    default: begin
                        request(0, $urandom, 8'($urandom_range(15)));
                        request(1, $urandom, 8'($urandom_range(15)));
                    end
                endcase
                #1;
                check("rnd_req_idle", arvalid, 1'b0);
            end
            @(negedge clk);
            serve_one($urandom_range(3), -1, ($urandom_range(9) == 0), $urandom,
                      1'b1, 1'($urandom_range(1)));
        end
        while (cli_valid[0] || cli_valid[1]) begin
            @(negedge clk);
            serve_one(0, -1, 1'b0, $urandom, 1'b1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
